// File: rtl/muldiv_unit_pkg.sv
// Shared MDOp encodings, default latencies and small helpers for the multiply/divide unit.
// Optional feature macro: MULDIV_MADD_EN (enables madd/maddu accumulate ops).
package muldiv_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MADD  = 3'b100;
  localparam logic [2:0] MD_MADDU = 3'b101;

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;

  // True for every MDOp code this build knows how to execute.
  function automatic logic op_supported(input logic [2:0] op);
`ifdef MULDIV_MADD_EN
    return (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MADDU});
`else
    return (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU});
`endif
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Counter width: enough for the longest latency, never below 4 bits.
  function automatic int cnt_width(input int mult_cycles, input int div_cycles);
    int longest;
    int w;
    longest = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    w = $clog2(longest + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/muldiv_calc.sv
// Combinational datapath: product, quotient/remainder and (with MULDIV_MADD_EN) the
// HI/LO accumulate. wr_en is low for divide by zero and for unknown ops.
module muldiv_calc
  import muldiv_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result,
  output logic        wr_en
);

  logic [63:0] prod_u;
  logic [63:0] prod_s;
  logic        div_signed;
  logic        div_zero;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] quo_raw;
  logic [31:0] rem_raw;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // The low 64 bits of a sign-extended 64x64 product are the signed 32x32 product.
  assign prod_u = {32'b0, op_a} * {32'b0, op_b};
  assign prod_s = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};

  // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case.
  assign div_signed = (op == MD_DIV);
  assign div_zero   = (op_b == 32'd0);
  assign mag_a      = op_a[31] ? (~op_a + 32'd1) : op_a;
  assign mag_b      = op_b[31] ? (~op_b + 32'd1) : op_b;
  assign dvd        = div_signed ? mag_a : op_a;
  assign dvs        = div_zero ? 32'd1 : (div_signed ? mag_b : op_b);
  assign quo_raw    = dvd / dvs;
  assign rem_raw    = dvd % dvs;
  assign quo_fix    = (div_signed && (op_a[31] ^ op_b[31])) ? (~quo_raw + 32'd1) : quo_raw;
  assign rem_fix    = (div_signed && op_a[31]) ? (~rem_raw + 32'd1) : rem_raw;

`ifndef MULDIV_MADD_EN
  logic unused_acc;
  assign unused_acc = ^{hi, lo};
`endif

  // NOTE: every output gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    result = '0;
    wr_en  = 1'b0;
    case (op)
      MD_MULT:  begin result = prod_s;             wr_en = 1'b1;      end
      MD_MULTU: begin result = prod_u;             wr_en = 1'b1;      end
      MD_DIV,
      MD_DIVU:  begin result = {rem_fix, quo_fix}; wr_en = !div_zero; end
`ifdef MULDIV_MADD_EN
      MD_MADD:  begin result = {hi, lo} + prod_s;  wr_en = 1'b1;      end
      MD_MADDU: begin result = {hi, lo} + prod_u;  wr_en = 1'b1;      end
`endif
      default:  begin result = '0;                 wr_en = 1'b0;      end
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Optional feature macro: MULDIV_MADD_EN (madd/maddu accumulate into HI/LO).
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        WrHI,
  input  logic        WrLO,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [63:0]      calc_result;
  logic             calc_wr_en;
  logic             launch;

  // Busy decodes the counter register only; Start never reaches it combinationally.
  assign Busy   = (cnt != '0);
  assign launch = Start && !Busy && op_supported(MDOp);

  muldiv_calc u_calc (
    .op     (op_q),
    .op_a   (op_a),
    .op_b   (op_b),
    .hi     (HI),
    .lo     (LO),
    .result (calc_result),
    .wr_en  (calc_wr_en)
  );

  // NOTE: state registers use non-blocking assignments so every update in this block
  // sees the pre-edge values, matching the hardware flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      op_q <= MD_MULT;
      op_a <= '0;
      op_b <= '0;
      HI   <= '0;
      LO   <= '0;
    end else if (Busy) begin
      if (cnt == CNT_W'(1)) begin
        cnt <= '0;
        if (calc_wr_en) begin
          HI <= calc_result[63:32];
          LO <= calc_result[31:0];
        end
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else if (launch) begin
      op_q <= MDOp;
      op_a <= A;
      op_b <= B;
      cnt  <= op_is_div(MDOp) ? DIV_LAT : MULT_LAT;
    end else if (!Start) begin
      // mthi/mtlo are only honoured when idle and not paired with a Start.
      if (WrHI) HI <= A;
      if (WrLO) LO <= A;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases from the test plan plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        WrHI;
  logic        WrLO;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .WrHI  (WrHI),
    .WrLO  (WrLO),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          m_valid = 0;
  bit          m_pending = 0;
  int          m_cyc = 0;
  int          m_commit_cyc = 0;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b, m_hi, m_lo;

  function automatic bit ref_legal(input logic [2:0] op);
`ifdef MULDIV_MADD_EN
    return op <= 3'd5;
`else
    return op <= 3'd3;
`endif
  endfunction

  // Returns 0 when HI/LO must stay unchanged.
  function automatic bit ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] hi, input logic [31:0] lo,
                                    output logic [63:0] res);
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    res = '0;
    case (op)
      3'd0: res = sa * sb;
      3'd1: res = {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 32'd0) return 0;
        res = {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        if (b == 32'd0) return 0;
        res = {a % b, a / b};
      end
      3'd4: res = {hi, lo} + 64'(sa * sb);
      3'd5: res = {hi, lo} + {32'b0, a} * {32'b0, b};
      default: return 0;
    endcase
    return 1;
  endfunction

  always @(posedge clk) begin
    logic [63:0] res;
    if (reset) begin
      m_valid   = 1;
      m_pending = 0;
      m_hi      = '0;
      m_lo      = '0;
    end else if (m_valid) begin
      if (m_pending) begin
        if (m_cyc + 1 == m_commit_cyc) begin
          m_pending = 0;
          if (ref_result(m_op, m_a, m_b, m_hi, m_lo, res)) begin
            m_hi = res[63:32];
            m_lo = res[31:0];
          end
        end
      end else if (Start) begin
        if (ref_legal(MDOp)) begin
          m_op = MDOp;
          m_a  = A;
          m_b  = B;
          m_pending = 1;
          m_commit_cyc = m_cyc + 1 + (((MDOp == 3'd2) || (MDOp == 3'd3)) ? DIV_N : MULT_N);
        end
      end else begin
        if (WrHI) m_hi = A;
        if (WrLO) m_lo = A;
      end
    end
    m_cyc++;
  end

  // One compare process, every cycle once the model is initialised.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cmp_busy", {31'b0, Busy}, {31'b0, m_pending});
      check("cmp_hi", HI, m_hi);
      check("cmp_lo", LO, m_lo);
    end
  end

  // Inputs the hazard unit must never produce.
  always @(posedge clk) begin
    if (m_valid && !reset &&
        ((Start && Busy) || ((WrHI || WrLO) && Busy) || (Start && (WrHI || WrLO)))) begin
      errors++;
      $display("FAIL illegal_input: Start=%b WrHI=%b WrLO=%b Busy=%b", Start, WrHI, WrLO, Busy);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // ---------------- stimulus helpers (all driving on the falling edge) ----------------
  task automatic idle();
    Start = 1'b0;
    WrHI  = 1'b0;
    WrLO  = 1'b0;
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
    @(negedge clk);
    Start = 1'b0;
  endtask

  // Starts in cycle 0, returns in cycle n+1 having checked Busy throughout.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n);
    launch(op, a, b);
    for (int i = 1; i <= n; i++) begin
      check($sformatf("%s_busy_c%0d", name, i), {31'b0, Busy}, 32'd1);
      @(negedge clk);
    end
    check($sformatf("%s_idle_c%0d", name, n + 1), {31'b0, Busy}, 32'd0);
  endtask

  task automatic write_hilo(input logic wh, input logic wl, input logic [31:0] val);
    WrHI = wh;
    WrLO = wl;
    A    = val;
    @(negedge clk);
    WrHI = 1'b0;
    WrLO = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    idle();
    reset = 1'b1;
    MDOp  = 3'd0;
    A     = '0;
    B     = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", {31'b0, Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("mult", MD_MULT, 32'hFFFF_FFFF, 32'd2, MULT_N);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFE);

    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, MULT_N);
    check("multu_hi", HI, 32'h0000_0001);
    check("multu_lo", LO, 32'hFFFF_FFFE);

    run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, DIV_N);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    run_op("divu", MD_DIVU, 32'd7, 32'd2, DIV_N);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);

    write_hilo(1'b1, 1'b0, 32'h1234_5678);
    check("mthi_hi", HI, 32'h1234_5678);
    check("mthi_lo", LO, 32'd3);
    run_op("divz", MD_DIVU, 32'd5, 32'd0, DIV_N);
    check("divz_hi", HI, 32'h1234_5678);
    check("divz_lo", LO, 32'd3);

    run_op("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N);
    check("divovf_lo", LO, 32'h8000_0000);
    check("divovf_hi", HI, 32'd0);

    // Back-to-back: second Start lands in the first op's commit-visible cycle.
    run_op("b2b_mult", MD_MULT, 32'd3, 32'd4, MULT_N);
    check("b2b_mult_lo", LO, 32'd12);
    check("b2b_mult_hi", HI, 32'd0);
    run_op("b2b_divu", MD_DIVU, 32'd20, 32'd6, DIV_N);
    check("b2b_lo", LO, 32'd3);
    check("b2b_hi", HI, 32'd2);

    // Reset in cycle 4 of a divide aborts it.
    write_hilo(1'b1, 1'b1, 32'hAAAA_5555);
    launch(MD_DIV, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", {31'b0, Busy}, 32'd0);
    check("rst_mid_hi", HI, 32'd0);
    check("rst_mid_lo", LO, 32'd0);
    repeat (DIV_N + 2) @(negedge clk);
    check("rst_nocommit_hi", HI, 32'd0);
    check("rst_nocommit_lo", LO, 32'd0);

`ifdef MULDIV_MADD_EN
    write_hilo(1'b1, 1'b0, 32'd0);
    write_hilo(1'b0, 1'b1, 32'hFFFF_FFFF);
    run_op("maddu", MD_MADDU, 32'd1, 32'd1, MULT_N);
    check("maddu_hi", HI, 32'd1);
    check("maddu_lo", LO, 32'd0);
    run_op("madd", MD_MADD, 32'hFFFF_FFFF, 32'd1, MULT_N);
    check("madd_hi", HI, 32'd0);
    check("madd_lo", LO, 32'hFFFF_FFFF);
`else
    write_hilo(1'b1, 1'b1, 32'h0BAD_CAFE);
    launch(MD_MADD, 32'd9, 32'd9);
    check("undef_busy", {31'b0, Busy}, 32'd0);
    @(negedge clk);
    check("undef_hi", HI, 32'h0BAD_CAFE);
    check("undef_lo", LO, 32'h0BAD_CAFE);
`endif
    launch(3'd7, 32'd9, 32'd9);
    check("undef7_busy", {31'b0, Busy}, 32'd0);

    // Randomized traffic; the compare process does the checking.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle();
      reset = ($urandom_range(0, 199) == 0);
      if (!m_pending && !reset) begin
        int r;
        r = $urandom_range(0, 9);
        A = rand_operand();
        B = rand_operand();
        if (r <= 4) begin
          Start = 1'b1;
          MDOp  = 3'($urandom_range(0, 7));
        end else if (r == 5) begin
          WrHI = 1'b1;
        end else if (r == 6) begin
          WrLO = 1'b1;
        end else if (r == 7) begin
          WrHI = 1'b1;
          WrLO = 1'b1;
        end
      end
      @(negedge clk);
    end
    idle();
    reset = 1'b0;
    for (int i = 0; i < DIV_N + 2 && m_pending; i++) @(negedge clk);
    check("drain_model_idle", {31'b0, m_pending}, 32'd0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
